gate_tt_checker: RTL and testbench

Hardware truth-table exerciser for the 2-input gate library. It drives all four input vectors onto a gate under test and captures the gate output after a programmable settle time. Each captured value is compared against a parameterised expected truth table, and the block reports pass/fail per vector. It is the stimulus and response end of the gate interface, used for on-chip self-test of the combinational gates.

---
 rtl/gate_tt_checker_if.sv | 37 +++
 rtl/gate_tt_checker.sv | 102 ++++++++++
 tb/tb_gate_tt_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_checker_if.sv
// Stimulus/response bundle between the truth-table checker and a 2-input gate.
// The master side is the checker; the slave side is the gate plus its controller.
interface gate_tt_checker_if;
    logic       start;
    logic       drv_a;
    logic       drv_b;
    logic       dut_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;

    modport master (
        input  start,
        input  dut_c,
        output drv_a,
        output drv_b,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_count
    );

    modport slave (
        output start,
        output dut_c,
        input  drv_a,
        input  drv_b,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_count
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Truth-table exerciser: sweeps {a,b}=0..3 onto a gate, samples its output
// after a settle window and reports per-vector mismatches against EXPECT.
module gate_tt_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = 4'b0001
) (
    input logic               clk,
    input logic               rst_n,
    gate_tt_checker_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SC = 4'(SETTLE_CYCLES);

    state_t     state_q;
    logic [1:0] idx_q;
    logic [3:0] hc_q;
    logic [1:0] drv_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] fail_q;
    logic [2:0] err_q;

    logic       mism;
    logic [3:0] fail_d;
    logic [2:0] err_d;

    // Results as they stand after folding in the vector sampled on this edge.
    always_comb begin
        mism   = (bus.dut_c != EXPECT[idx_q]);
        fail_d = fail_q | ({3'b000, mism} << idx_q);
        err_d  = err_q + {2'b00, mism};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            hc_q    <= 4'd0;
            drv_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 4'b0000;
            err_q   <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DRIVE: begin
                    if (hc_q != SC) begin
                        hc_q <= hc_q + 4'd1;
                    end else begin
                        hc_q   <= 4'd0;
                        fail_q <= fail_d;
                        err_q  <= err_d;
                        if (idx_q == 2'd3) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            drv_q   <= 2'b00;
                            pass_q  <= (err_d == 3'd0);
                        end else begin
                            idx_q <= idx_q + 2'd1;
                            drv_q <= idx_q + 2'd1;
                        end
                    end
                end
                // IDLE and DONE accept a start identically.
                default: begin
                    drv_q <= 2'b00;
                    if (bus.start) begin
                        state_q <= DRIVE;
                        idx_q   <= 2'd0;
                        hc_q    <= 4'd0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        fail_q  <= 4'b0000;
                        err_q   <= 3'd0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.drv_a     = drv_q[1];
    assign bus.drv_b     = drv_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench: default NOR checker plus an AND checker with zero settle time.
// Cycle n is counted from the edge that accepts start; outputs sampled on negedge.
module tb_gate_tt_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   gate_sel = 0;

    always #5 clk = ~clk;

    gate_tt_checker_if b1 ();
    gate_tt_checker_if b2 ();

    gate_tt_checker u_nor (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    gate_tt_checker #(
        .SETTLE_CYCLES (0),
        .EXPECT        (4'b1000)
    ) u_and (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.master)
    );

    // 0: NOR, 1: NAND, 2: stuck at 0
    always_comb begin
        case (gate_sel)
            0:       b1.dut_c = ~(b1.drv_a | b1.drv_b);
            1:       b1.dut_c = ~(b1.drv_a & b1.drv_b);
            default: b1.dut_c = 1'b0;
        endcase
    end

    assign b2.dut_c = b2.drv_a & b2.drv_b;

    // Pulses start at n=0, applies extra[n] at each later negedge, and records
    // the drive sequence over n=1..12 plus the first done cycle and done count.
    task automatic sweep(input logic [31:0] extra, output logic [23:0] seq,
                         output int dn, output int dcnt);
        seq  = '0;
        dn   = -1;
        dcnt = 0;
        @(negedge clk);
        b1.start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            b1.start = extra[n];
            if (n <= 12) seq[2*(12-n) +: 2] = {b1.drv_a, b1.drv_b};
            if (b1.done) begin
                dcnt++;
                if (dn < 0) dn = n;
            end
        end
        b1.start = 1'b0;
    endtask

    task automatic test_reset;
        b1.start = 1'b0;
        b2.start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({b1.drv_a, b1.drv_b, b1.busy, b1.done, b1.pass} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {b1.drv_a, b1.drv_b, b1.busy, b1.done, b1.pass});
        end
        total++;
        if (b1.fail_mask !== 4'b0000 || b1.err_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_res got=%b/%0d want=0000/0",
                     b1.fail_mask, b1.err_count);
        end
        total++;
        if ({b2.drv_a, b2.drv_b, b2.busy, b2.done, b2.pass} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl2 got=%b want=00000",
                     {b2.drv_a, b2.drv_b, b2.busy, b2.done, b2.pass});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nor;
        logic [23:0] seq;
        int          dn;
        int          dc;
        gate_sel = 0;
        sweep(32'd0, seq, dn, dc);
        total++;
        if (seq !== 24'b000000_010101_101010_111111) begin
            bad++;
            $display("FAIL nor_seq got=%h want=015abf", seq);
        end
        total++;
        if (dn !== 13 || dc !== 1) begin
            bad++;
            $display("FAIL nor_done got=n%0d x%0d want=n13 x1", dn, dc);
        end
        total++;
        if (b1.pass !== 1'b1 || b1.fail_mask !== 4'b0000 ||
            b1.err_count !== 3'd0) begin
            bad++;
            $display("FAIL nor_res got=%b/%b/%0d want=1/0000/0",
                     b1.pass, b1.fail_mask, b1.err_count);
        end
    endtask

    task automatic test_nand;
        logic [23:0] seq;
        int          dn;
        int          dc;
        gate_sel = 1;
        sweep(32'd0, seq, dn, dc);
        total++;
        if (dn !== 13) begin
            bad++;
            $display("FAIL nand_done got=%0d want=13", dn);
        end
        total++;
        if (b1.pass !== 1'b0 || b1.fail_mask !== 4'b0110 ||
            b1.err_count !== 3'd2) begin
            bad++;
            $display("FAIL nand_res got=%b/%b/%0d want=0/0110/2",
                     b1.pass, b1.fail_mask, b1.err_count);
        end
    endtask

    task automatic test_stuck0;
        logic [23:0] seq;
        int          dn;
        int          dc;
        gate_sel = 2;
        sweep(32'd0, seq, dn, dc);
        total++;
        if (b1.pass !== 1'b0 || b1.fail_mask !== 4'b0001 ||
            b1.err_count !== 3'd1) begin
            bad++;
            $display("FAIL stuck0_res got=%b/%b/%0d want=0/0001/1",
                     b1.pass, b1.fail_mask, b1.err_count);
        end
    endtask

    task automatic test_start_in_drive;
        logic [23:0] seq;
        int          dn;
        int          dc;
        gate_sel = 1;
        sweep(32'h0000_0954, seq, dn, dc);
        total++;
        if (dn !== 13 || dc !== 1) begin
            bad++;
            $display("FAIL rpt_done got=n%0d x%0d want=n13 x1", dn, dc);
        end
        total++;
        if (seq !== 24'b000000_010101_101010_111111) begin
            bad++;
            $display("FAIL rpt_seq got=%h want=015abf", seq);
        end
        total++;
        if (b1.fail_mask !== 4'b0110 || b1.err_count !== 3'd2) begin
            bad++;
            $display("FAIL rpt_res got=%b/%0d want=0110/2",
                     b1.fail_mask, b1.err_count);
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] seq;
        int          dn;
        int          dc;
        int          stray;
        gate_sel = 0;
        @(negedge clk);
        b1.start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            b1.start = 1'b0;
        end
        total++;
        if ({b1.drv_a, b1.drv_b, b1.busy} !== 3'b101) begin
            bad++;
            $display("FAIL mid_pre got=%b want=101",
                     {b1.drv_a, b1.drv_b, b1.busy});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({b1.drv_a, b1.drv_b, b1.busy, b1.done, b1.pass,
             b1.fail_mask, b1.err_count} !== 12'b0) begin
            bad++;
            $display("FAIL mid_rst got=%b want=0",
                     {b1.drv_a, b1.drv_b, b1.busy, b1.done, b1.pass,
                      b1.fail_mask, b1.err_count});
        end
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (b1.done) stray++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (b1.done) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL mid_nodone got=%0d want=0", stray);
        end
        sweep(32'd0, seq, dn, dc);
        total++;
        if (dn !== 13 || b1.pass !== 1'b1 || b1.fail_mask !== 4'b0000 ||
            b1.err_count !== 3'd0) begin
            bad++;
            $display("FAIL mid_after got=n%0d %b/%b/%0d want=n13 1/0000/0",
                     dn, b1.pass, b1.fail_mask, b1.err_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:1] busy_obs;
        logic [12:1] done_obs;
        @(negedge clk);
        b2.start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 9) b2.start = 1'b0;
            busy_obs[n] = b2.busy;
            done_obs[n] = b2.done;
            if (b2.done) begin
                total++;
                if (b2.pass !== 1'b1 || b2.fail_mask !== 4'b0000) begin
                    bad++;
                    $display("FAIL b2b_pass n=%0d got=%b/%b want=1/0000",
                             n, b2.pass, b2.fail_mask);
                end
            end
        end
        total++;
        if (done_obs !== 12'b001000010000) begin
            bad++;
            $display("FAIL b2b_done got=%b want=001000010000", done_obs);
        end
        total++;
        if (busy_obs !== 12'b000111101111) begin
            bad++;
            $display("FAIL b2b_busy got=%b want=000111101111", busy_obs);
        end
    endtask

    initial begin
        test_reset();
        test_nor();
        test_nand();
        test_stuck0();
        test_start_in_drive();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
